// File: rtl/ipfilter_ctrl_if.sv
// Bundle of parse-result, table-config and verdict signals for ipfilter_ctrl.
// The sequencer uses the slave modport; the producer/consumer side uses master.
interface ipfilter_ctrl_if #(
  parameter int unsigned NUM_RULES = 8
);
  localparam int unsigned RW = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;

  logic          res_vld;
  logic          res_ipv4;
  logic [31:0]   res_src;
  logic [31:0]   res_dst;
  logic          cfg_wr;
  logic [RW-1:0] cfg_idx;
  logic [2:0]    cfg_sel;
  logic [31:0]   cfg_wdata;
  logic          cfg_default_drop;
  logic [RW-1:0] cfg_rd_idx;
  logic [31:0]   cfg_rd_hits;
  logic          vrd_valid;
  logic          vrd_ready;
  logic          vrd_drop;
  logic          vrd_hit;
  logic [RW-1:0] vrd_rule;
  logic          busy;
  logic [15:0]   ovf_cnt;

  modport master (
    output res_vld, res_ipv4, res_src, res_dst,
    output cfg_wr, cfg_idx, cfg_sel, cfg_wdata, cfg_default_drop, cfg_rd_idx,
    output vrd_ready,
    input  cfg_rd_hits, vrd_valid, vrd_drop, vrd_hit, vrd_rule, busy, ovf_cnt
  );

  modport slave (
    input  res_vld, res_ipv4, res_src, res_dst,
    input  cfg_wr, cfg_idx, cfg_sel, cfg_wdata, cfg_default_drop, cfg_rd_idx,
    input  vrd_ready,
    output cfg_rd_hits, vrd_valid, vrd_drop, vrd_hit, vrd_rule, busy, ovf_cnt
  );
endinterface

// File: rtl/ipfilter_ctrl.sv
// Rule-lookup sequencer: pending slot -> IDLE/SCAN/PUSH scan -> in-order verdict FIFO.
// Optional per-rule hit counters are built when IPFILTER_HIT_CNT_EN is defined.
module ipfilter_ctrl #(
  parameter int unsigned NUM_RULES  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  ipfilter_ctrl_if.slave bus
);
  localparam int unsigned RW = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_PUSH = 2'd2} state_t;
  typedef struct packed {
    logic          drop;
    logic          hit;
    logic [RW-1:0] rule;
  } verdict_t;

  logic [31:0] r_t_src   [NUM_RULES];
  logic [31:0] r_t_smask [NUM_RULES];
  logic [31:0] r_t_dst   [NUM_RULES];
  logic [31:0] r_t_dmask [NUM_RULES];
  logic        r_t_drop  [NUM_RULES];
  logic        r_t_en    [NUM_RULES];

  logic          r_pend_vld, r_pend_ipv4;
  logic [31:0]   r_pend_src, r_pend_dst;
  logic [15:0]   r_ovf;
  state_t        r_state;
  logic [RW-1:0] r_idx;
  logic [31:0]   r_wsrc, r_wdst;
  verdict_t      r_vrd;
  verdict_t      r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr, r_rptr;

  logic w_cfg_in_range, w_consume, w_match, w_last, w_empty, w_full, w_push, w_pop;
  verdict_t w_head;

  assign w_cfg_in_range = 32'(bus.cfg_idx) < NUM_RULES;
  assign w_consume      = (r_state == S_IDLE) && r_pend_vld;
  assign w_match = r_t_en[r_idx]
                && (((r_wsrc ^ r_t_src[r_idx]) & r_t_smask[r_idx]) == 32'd0)
                && (((r_wdst ^ r_t_dst[r_idx]) & r_t_dmask[r_idx]) == 32'd0);
  assign w_last  = (r_idx == RW'(NUM_RULES - 1));
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = (r_state == S_PUSH) && !w_full;
  assign w_pop   = !w_empty && bus.vrd_ready;
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  // Rule table write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_RULES; i++) begin
        r_t_src[i]   <= '0;
        r_t_smask[i] <= '0;
        r_t_dst[i]   <= '0;
        r_t_dmask[i] <= '0;
        r_t_drop[i]  <= 1'b0;
        r_t_en[i]    <= 1'b0;
      end
    end else if (bus.cfg_wr && w_cfg_in_range) begin
      case (bus.cfg_sel)
        3'd0: r_t_src[bus.cfg_idx]   <= bus.cfg_wdata;
        3'd1: r_t_smask[bus.cfg_idx] <= bus.cfg_wdata;
        3'd2: r_t_dst[bus.cfg_idx]   <= bus.cfg_wdata;
        3'd3: r_t_dmask[bus.cfg_idx] <= bus.cfg_wdata;
        3'd4: begin
          r_t_drop[bus.cfg_idx] <= bus.cfg_wdata[1];
          r_t_en[bus.cfg_idx]   <= bus.cfg_wdata[0];
        end
        default: ;
      endcase
    end
  end

  // One-deep pending slot; a result arriving while it is held and not consumed is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_vld  <= 1'b0;
      r_pend_ipv4 <= 1'b0;
      r_pend_src  <= '0;
      r_pend_dst  <= '0;
      r_ovf       <= '0;
    end else begin
      if (bus.res_vld && (!r_pend_vld || w_consume)) begin
        r_pend_vld  <= 1'b1;
        r_pend_ipv4 <= bus.res_ipv4;
        r_pend_src  <= bus.res_src;
        r_pend_dst  <= bus.res_dst;
      end else if (w_consume) begin
        r_pend_vld <= 1'b0;
      end
      if (bus.res_vld && r_pend_vld && !w_consume && (r_ovf != 16'hFFFF))
        r_ovf <= r_ovf + 16'd1;
    end
  end

  // Scan sequencer; the lowest matching index wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_wsrc  <= '0;
      r_wdst  <= '0;
      r_vrd   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (r_pend_vld) begin
          r_wsrc <= r_pend_src;
          r_wdst <= r_pend_dst;
          r_idx  <= '0;
          if (r_pend_ipv4) begin
            r_state <= S_SCAN;
          end else begin
            r_vrd   <= '0;
            r_state <= S_PUSH;
          end
        end
        S_SCAN: begin
          if (w_match) begin
            r_vrd   <= {r_t_drop[r_idx], 1'b1, r_idx};
            r_state <= S_PUSH;
          end else if (w_last) begin
            r_vrd   <= {bus.cfg_default_drop, 1'b0, RW'(0)};
            r_state <= S_PUSH;
          end else begin
            r_idx <= r_idx + RW'(1);
          end
        end
        S_PUSH:  if (!w_full) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Verdict FIFO; push is held off while full even if a pop happens that cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= r_vrd;
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  assign bus.vrd_valid = !w_empty;
  assign bus.vrd_drop  = w_head.drop;
  assign bus.vrd_hit   = w_head.hit;
  assign bus.vrd_rule  = w_head.rule;
  assign bus.busy      = (r_state != S_IDLE) || r_pend_vld;
  assign bus.ovf_cnt   = r_ovf;

`ifdef IPFILTER_HIT_CNT_EN
  logic [31:0] r_hits [NUM_RULES];

  // Saturating per-rule hit counters, cleared by a ctrl write to that rule
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_RULES; i++) r_hits[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_RULES; i++) begin
        if (bus.cfg_wr && (bus.cfg_sel == 3'd4) && (bus.cfg_idx == RW'(i)))
          r_hits[i] <= '0;
        else if (w_push && r_vrd.hit && (r_vrd.rule == RW'(i)) && (r_hits[i] != 32'hFFFF_FFFF))
          r_hits[i] <= r_hits[i] + 32'd1;
      end
    end
  end

  assign bus.cfg_rd_hits = (32'(bus.cfg_rd_idx) < NUM_RULES) ? r_hits[bus.cfg_rd_idx] : 32'd0;
`else
  logic w_unused_rd_idx;
  assign w_unused_rd_idx = ^bus.cfg_rd_idx;
  assign bus.cfg_rd_hits = 32'd0;
`endif

endmodule

// File: tb/tb_ipfilter_ctrl.sv
// Self-checking bench for ipfilter_ctrl: directed latency/priority/backpressure/reset
// steps plus a randomized phase checked against a rule-table reference model.
module tb_ipfilter_ctrl;
  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ipfilter_ctrl_if #(.NUM_RULES(N)) bus ();
  ipfilter_ctrl #(.NUM_RULES(N), .FIFO_DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int passed = 0;
  int total  = 0;

  logic [31:0] m_src [N], m_smask [N], m_dst [N], m_dmask [N], m_hits [N];
  logic        m_drop [N], m_en [N];
  logic [4:0]  expq [$];
  logic [31:0] masks [4] = '{32'h0, 32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_FFFF};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pops (and checks) the head verdict whenever the consumer accepts it, then advances one cycle
  task automatic tick();
    logic [4:0] e;
    if (bus.vrd_valid === 1'b1 && bus.vrd_ready === 1'b1) begin
      check("verdict_expected", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        check("vrd_drop", 32'(bus.vrd_drop), 32'(e[4]));
        check("vrd_hit",  32'(bus.vrd_hit),  32'(e[3]));
        check("vrd_rule", 32'(bus.vrd_rule), 32'(e[2:0]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_src[k] = '0; m_smask[k] = '0; m_dst[k] = '0; m_dmask[k] = '0;
      m_drop[k] = 1'b0; m_en[k] = 1'b0; m_hits[k] = '0;
    end
    expq.delete();
  endfunction

  // Expected verdict {drop,hit,rule[2:0]} from the current table, first enabled match wins
  function automatic logic [4:0] ref_verdict(input logic ipv4, input logic [31:0] s, input logic [31:0] d);
    if (!ipv4) return 5'b0;
    for (int k = 0; k < N; k++)
      if (m_en[k] && ((s ^ m_src[k]) & m_smask[k]) == 0 && ((d ^ m_dst[k]) & m_dmask[k]) == 0)
        return {m_drop[k], 1'b1, 3'(k)};
    return {bus.cfg_default_drop, 1'b0, 3'b0};
  endfunction

  task automatic cfg_write(input int idx, input logic [2:0] sel, input logic [31:0] d);
    bus.cfg_wr = 1'b1; bus.cfg_idx = 3'(idx); bus.cfg_sel = sel; bus.cfg_wdata = d;
    case (sel)
      3'd0: m_src[idx] = d;
      3'd1: m_smask[idx] = d;
      3'd2: m_dst[idx] = d;
      3'd3: m_dmask[idx] = d;
      default: begin m_drop[idx] = d[1]; m_en[idx] = d[0]; m_hits[idx] = '0; end
    endcase
    tick();
    bus.cfg_wr = 1'b0;
  endtask

  task automatic send(input logic ipv4, input logic [31:0] s, input logic [31:0] d, input bit accepted);
    logic [4:0] v;
    if (accepted) begin
      v = ref_verdict(ipv4, s, d);
      if (v[3]) m_hits[v[2:0]]++;
      expq.push_back(v);
    end
    bus.res_vld = 1'b1; bus.res_ipv4 = ipv4; bus.res_src = s; bus.res_dst = d;
    tick();
    bus.res_vld = 1'b0;
  endtask

  // Sends one packet to an idle block and checks cycles from res_vld to vrd_valid
  task automatic send_timed(input string tag, input logic ipv4, input logic [31:0] s,
                            input logic [31:0] d, input int exp_lat);
    int cnt;
    send(ipv4, s, d, 1'b1);
    cnt = 1;
    while (bus.vrd_valid !== 1'b1 && cnt < 40) begin
      tick();
      cnt++;
    end
    check(tag, 32'(cnt), 32'(exp_lat));
    ticks(3);
  endtask

  task automatic check_hits(input int idx, input string tag);
    bus.cfg_rd_idx = 3'(idx);
    #1;
`ifdef IPFILTER_HIT_CNT_EN
    check(tag, bus.cfg_rd_hits, m_hits[idx]);
`else
    check(tag, bus.cfg_rd_hits, 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] s, d;
    int j;
    rst_n = 1'b0;
    bus.res_vld = 0; bus.res_ipv4 = 0; bus.res_src = 0; bus.res_dst = 0;
    bus.cfg_wr = 0; bus.cfg_idx = 0; bus.cfg_sel = 0; bus.cfg_wdata = 0;
    bus.cfg_default_drop = 0; bus.cfg_rd_idx = 0; bus.vrd_ready = 1;
    model_reset();
    ticks(3);
    check("rst_vrd_valid", 32'(bus.vrd_valid), 0);
    check("rst_busy",      32'(bus.busy), 0);
    check("rst_ovf",       32'(bus.ovf_cnt), 0);
    check("rst_vrd_drop",  32'(bus.vrd_drop), 0);
    check_hits(0, "rst_hits");
    rst_n = 1'b1;
    ticks(2);

    // Match on rule 0 (10.0.0.0/8, drop)
    cfg_write(0, 3'd0, 32'h0A00_0000);
    cfg_write(0, 3'd1, 32'hFF00_0000);
    cfg_write(0, 3'd4, 32'd3);
    send_timed("lat_match_r0", 1'b1, 32'h0A01_0203, $urandom, 4);

    // Default action with every rule disabled
    cfg_write(0, 3'd4, 32'd0);
    bus.cfg_default_drop = 1'b1;
    send_timed("lat_default_drop", 1'b1, $urandom, $urandom, N + 3);
    bus.cfg_default_drop = 1'b0;
    send_timed("lat_default_pass", 1'b1, $urandom, $urandom, N + 3);

    // Priority: rule 2 (pass) beats rule 5 (drop) on the same destination
    cfg_write(2, 3'd2, 32'hC0A8_0001); cfg_write(2, 3'd3, 32'hFFFF_FFFF); cfg_write(2, 3'd4, 32'd1);
    cfg_write(5, 3'd2, 32'hC0A8_0001); cfg_write(5, 3'd3, 32'hFFFF_FFFF); cfg_write(5, 3'd4, 32'd3);
    send(1'b1, $urandom, 32'hC0A8_0001, 1'b1);
    check("busy_scanning", 32'(bus.busy), 1);
    ticks(12);
    send_timed("lat_prio_r2", 1'b1, $urandom, 32'hC0A8_0001, 6);
    send_timed("lat_non_ipv4", 1'b0, $urandom, 32'hC0A8_0001, 3);

    // Randomized rules, packets and consumer stalls
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        j = $urandom_range(0, N - 1);
        cfg_write(j, 3'd0, $urandom);
        cfg_write(j, 3'd1, masks[$urandom_range(0, 3)]);
        cfg_write(j, 3'd2, $urandom);
        cfg_write(j, 3'd3, masks[$urandom_range(0, 3)]);
        cfg_write(j, 3'd4, 32'($urandom_range(0, 3)));
      end
      j = $urandom_range(0, N - 1);
      if ($urandom_range(0, 1) == 0) begin
        s = (m_src[j] & m_smask[j]) | ($urandom & ~m_smask[j]);
        d = (m_dst[j] & m_dmask[j]) | ($urandom & ~m_dmask[j]);
      end else begin
        s = $urandom; d = $urandom;
      end
      bus.cfg_default_drop = 1'($urandom_range(0, 1));
      send(1'($urandom_range(0, 7) != 0), s, d, 1'b1);
      for (int c = 0; c < 14; c++) begin
        bus.vrd_ready = 1'($urandom_range(0, 3) != 0);
        tick();
      end
    end
    bus.vrd_ready = 1'b1;
    ticks(10);
    check("rand_drained", 32'(expq.size()), 0);
    check("rand_no_ovf",  32'(bus.ovf_cnt), 0);
    for (int k = 0; k < N; k++) check_hits(k, "rand_hits");

    // Hit counters: 5 hits on rule 1, then clear
    for (int k = 0; k < N; k++) cfg_write(k, 3'd4, 32'd0);
    cfg_write(1, 3'd1, 32'd0); cfg_write(1, 3'd3, 32'd0); cfg_write(1, 3'd4, 32'd1);
    for (int p = 0; p < 5; p++) begin
      send(1'b1, $urandom, $urandom, 1'b1);
      ticks(8);
    end
    check_hits(1, "hits_rule1");
    cfg_write(1, 3'd4, 32'd1);
    check_hits(1, "hits_cleared");

    // Backpressure: rule 0 drops 10/8, rule 1 passes everything else
    cfg_write(0, 3'd0, 32'h0A00_0000); cfg_write(0, 3'd1, 32'hFF00_0000);
    cfg_write(0, 3'd3, 32'd0);         cfg_write(0, 3'd4, 32'd3);
    bus.vrd_ready = 1'b0;
    for (int p = 0; p < 8; p++) begin
      send(1'b1, (p % 2 == 0) ? 32'h0A00_0000 | 32'($urandom_range(0, 255)) : 32'h0B00_0001,
           $urandom, p < 6);
      if (p == 6) check("ovf_one", 32'(bus.ovf_cnt), 1);
      if (p == 7) check("ovf_two", 32'(bus.ovf_cnt), 2);
      ticks(9);
    end
    check("bp_valid", 32'(bus.vrd_valid), 1);
    check("bp_busy",  32'(bus.busy), 1);
    bus.vrd_ready = 1'b1;
    ticks(25);
    check("bp_drained", 32'(expq.size()), 0);
    check_hits(0, "bp_hits_r0");

    // Reset during the scan at index 3
    cfg_write(0, 3'd4, 32'd0); cfg_write(1, 3'd4, 32'd0);
    cfg_write(7, 3'd1, 32'd0); cfg_write(7, 3'd3, 32'd0); cfg_write(7, 3'd4, 32'd3);
    send(1'b1, $urandom, $urandom, 1'b0);
    ticks(4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.vrd_valid), 0);
    check("mid_rst_busy",  32'(bus.busy), 0);
    check("mid_rst_ovf",   32'(bus.ovf_cnt), 0);
    model_reset();
    check_hits(0, "mid_rst_hits");
    tick();
    rst_n = 1'b1;
    tick();
    bus.cfg_default_drop = 1'b0;
    send_timed("post_rst_cleared", 1'b1, $urandom, $urandom, N + 3);
    check("post_rst_drained", 32'(expq.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
